// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core. One FIPS-197 round per clock, with the round keys
// expanded on the fly. Blocks enter and leave over valid/ready handshakes.
module aes128_enc_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       state, state_nxt;
  logic [127:0] st, rk;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [127:0] nk, sr, round_out;
  logic         last;

  // A saturating compare keeps an out-of-range rnd from ever starting another round.
  assign last = (rnd >= 4'd10);

  always_comb begin
    nk        = key_expand(rk, rcon);
    sr        = shift_rows(sub_bytes(st));
    round_out = last ? (sr ^ nk) : (mix_columns(sr) ^ nk);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ROUND;
      ROUND:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= '0;
      rk   <= '0;
      rnd  <= '0;
      rcon <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st   <= datain ^ key;
            rk   <= key;
            rnd  <= 4'd1;
            rcon <= 8'h01;
          end
        end
        ROUND: begin
          st   <= round_out;
          rk   <= nk;
          rcon <= xtime(rcon);
          if (!last) rnd <= rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ROUND) || (state == DONE);
  assign dataout   = st;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed bench for aes128_enc_iter using the FIPS-197 App. B and App. C.1 vectors.
module tb_aes128_enc_iter;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] datain = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] dataout;

  int errors = 0;
  int checks = 0;

  aes128_enc_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Offers one block; returns at 1 ns after the accept edge.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ready_before_accept", 128'(in_ready), 128'd1);
    datain   = pt;
    key      = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("busy_after_accept", 128'(busy), 128'd1);
  endtask

  task automatic waitOutput(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic completeOutput();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("valid_drop_after_handshake", 128'(out_valid), 128'd0);
    checkOutput("ready_after_handshake", 128'(in_ready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int seen_valid;
    int cyc, nacc, nres;
    int acc [2];
    logic [127:0] res [2];
    logic will;

    // Reset values while rst is held.
    #2;
    checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_dataout", dataout, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // App. B with exact accept-to-valid latency.
    applyStimulus(PT_B, KEY_B);
    waitOutput(lat);
    checkOutput("appB_latency", 128'(lat), 128'd10);
    checkOutput("appB_dataout", dataout, CT_B);
    checkOutput("appB_in_ready_low", 128'(in_ready), 128'd0);
    checkOutput("appB_busy_done", 128'(busy), 128'd1);
    completeOutput();

    // App. C.1 held under back-pressure while a new block is offered.
    applyStimulus(PT_C, KEY_C);
    waitOutput(lat);
    checkOutput("appC_latency", 128'(lat), 128'd10);
    datain   = PT_B;
    key      = KEY_B;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
      checkOutput("bp_dataout", dataout, CT_C);
      checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    completeOutput();

    // App. B with datain/key scrambled every cycle after acceptance.
    applyStimulus(PT_B, KEY_B);
    lat = 0;
    while (!out_valid && lat < 30) begin
      datain = {$urandom, $urandom, $urandom, $urandom};
      key    = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("midchange_latency", 128'(lat), 128'd10);
    checkOutput("midchange_dataout", dataout, CT_B);
    completeOutput();

    // Reset asserted between edges while rnd == 5.
    applyStimulus(PT_B, KEY_B);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_in_ready", 128'(in_ready), 128'd1);
    checkOutput("midreset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("midreset_busy", 128'(busy), 128'd0);
    checkOutput("midreset_dataout", dataout, 128'd0);
    seen_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    checkOutput("midreset_no_valid_pulse", 128'(seen_valid), 128'd0);
    @(posedge clk); #1;
    applyStimulus(PT_C, KEY_C);
    waitOutput(lat);
    checkOutput("postreset_latency", 128'(lat), 128'd10);
    checkOutput("postreset_dataout", dataout, CT_C);
    completeOutput();

    // Back-to-back with out_ready and in_valid held high.
    out_ready = 1'b1;
    datain    = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    cyc  = 0;
    nacc = 0;
    nres = 0;
    acc  = '{0, 0};
    res  = '{128'd0, 128'd0};
    while (nres < 2 && cyc < 60) begin
      will = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (will) begin
        if (nacc < 2) acc[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          datain = PT_C;
          key    = KEY_C;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (nres < 2) res[nres] = dataout;
        nres++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("b2b_accepts", 128'(nacc), 128'd2);
    checkOutput("b2b_results", 128'(nres), 128'd2);
    checkOutput("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);
    checkOutput("b2b_first", res[0], CT_B);
    checkOutput("b2b_second", res[1], CT_C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
